// File: rtl/sram_req_responder.sv
// On-chip stand-in for the external SRAM controller: accepts a level-held
// read/write request, waits LATENCY cycles, then performs the access and pulses o_ACK.
module sram_req_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_rden,
  input  logic        i_wren,
  output logic [31:0] o_rdata,
  output logic        o_ACK,
  output logic        o_busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            op_wr;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      bmask_q;
  logic            accept;
  logic            enter_ack;
  logic            commit_wr;
  logic [AW-1:0]   commit_idx;
  logic [31:0]     commit_wdata;
  logic [3:0]      commit_bmask;
  logic [31:0]     mem [MEM_WORDS];
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = be[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    enter_ack = 1'b0;
    case (state)
      IDLE: begin
        if (i_wren || i_rden) begin
          accept  = 1'b1;
          cnt_nxt = CNT_INIT;
          if (LATENCY == 1) begin
            state_nxt = ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge, so the live inputs are used.
  always_comb begin
    if (state == IDLE) begin
      commit_wr    = i_wren;
      commit_idx   = i_addr[AW+1:2];
      commit_wdata = i_wdata;
      commit_bmask = i_bmask;
    end else begin
      commit_wr    = op_wr;
      commit_idx   = idx_q;
      commit_wdata = wdata_q;
      commit_bmask = bmask_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      o_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) op_wr <= i_wren;
      if (enter_ack && !commit_wr) o_rdata <= mem[commit_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= i_addr[AW+1:2];
      wdata_q <= i_wdata;
      bmask_q <= i_bmask;
    end
  end

  // Reset on the ACK-entry edge must drop the write, hence the explicit gate.
  always_ff @(posedge i_clk) begin
    if (!i_rst && enter_ack && commit_wr) begin
      mem[commit_idx] <= merge_bytes(mem[commit_idx], commit_wdata, commit_bmask);
    end
  end

  assign o_ACK  = (state == ACK);
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sram_req_responder.sv
// Directed bench for sram_req_responder: table of transactions on a LATENCY=3
// instance, reset corner sequences, and ACK spacing for LATENCY 1, 3 and 15.
module tb_sram_req_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        rden;
  logic        wren;

  logic [31:0] rdata3;
  logic        ack3, busy3;
  logic [31:0] unused_rdata1, unused_rdata15;
  logic        ack1, ack15, unused_busy1, unused_busy15;

  int n_checks = 0;
  int n_fail   = 0;

  sram_req_responder #(.MEM_WORDS(1024), .LATENCY(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_rden(rden), .i_wren(wren), .o_rdata(rdata3), .o_ACK(ack3), .o_busy(busy3)
  );

  sram_req_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_rden(rden), .i_wren(wren), .o_rdata(unused_rdata1), .o_ACK(ack1), .o_busy(unused_busy1)
  );

  sram_req_responder #(.MEM_WORDS(1024), .LATENCY(15)) dut15 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_rden(rden), .i_wren(wren), .o_rdata(unused_rdata15), .o_ACK(ack15), .o_busy(unused_busy15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int  cyc;
    bit  got;
    @(negedge clk);
    wren  = v.wr;
    rden  = v.rd;
    addr  = v.addr;
    wdata = v.wdata;
    bmask = v.bmask;
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({nm, " busy"}, {31'b0, busy3}, 32'd1);
      if (ack3) got = 1;
    end
    wren = 1'b0;
    rden = 1'b0;
    check({nm, " latency"}, cyc, 32'd3);
    if (v.chk) check({nm, " rdata"}, rdata3, v.exp);
    @(posedge clk); #1;
    check({nm, " ack one cycle"}, {31'b0, ack3}, 32'd0);
    if (v.chk) check({nm, " rdata held"}, rdata3, v.exp);
    @(posedge clk); #1;
    check({nm, " idle busy"}, {31'b0, busy3}, 32'd0);
  endtask

  task automatic watch_no_ack(input string nm, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ack3) seen = 1;
    end
    check(nm, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    int   cyc;
    bit   got;
    int   lat[3];
    int   last[3];
    int   cnt[3];
    logic a[3];
    vec_t rd20;

    vecs[0] = '{1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h10,   32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h10,   32'h11223344, 4'b0101, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h10,   32'h0,        4'b0000, 1'b1, 32'hDE22BE44};
    vecs[4] = '{1'b0, 1'b1, 32'h1010, 32'h0,        4'b0000, 1'b1, 32'hDE22BE44};
    vecs[5] = '{1'b1, 1'b1, 32'h14,   32'h55AA55AA, 4'b1111, 1'b1, 32'hDE22BE44};
    vecs[6] = '{1'b0, 1'b1, 32'h14,   32'h0,        4'b0000, 1'b1, 32'h55AA55AA};
    vecs[7] = '{1'b1, 1'b0, 32'h20,   32'h0BADC0DE, 4'b1111, 1'b1, 32'h55AA55AA};
    vecs[8] = '{1'b1, 1'b0, 32'h20,   32'hFFFFFFFF, 4'b0000, 1'b1, 32'h55AA55AA};
    vecs[9] = '{1'b0, 1'b1, 32'h20,   32'h0,        4'b0000, 1'b1, 32'h0BADC0DE};
    rd20    = '{1'b0, 1'b1, 32'h20,   32'h0,        4'b0000, 1'b1, 32'h0BADC0DE};

    // Reset held with a read pending
    rst = 1'b1; rden = 1'b1; wren = 1'b0;
    addr = 32'h10; wdata = 32'h0; bmask = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset ack",   {31'b0, ack3},  32'd0);
      check("reset busy",  {31'b0, busy3}, 32'd0);
      check("reset rdata", rdata3,         32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack3) got = 1;
    end
    rden = 1'b0;
    check("post-reset read latency", cyc, 32'd3);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the write is in BUSY
    @(negedge clk);
    wren = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; bmask = 4'b1111;
    @(posedge clk); #1;
    check("abort1 busy", {31'b0, busy3}, 32'd1);
    @(negedge clk);
    rst = 1'b1; wren = 1'b0;
    @(posedge clk); #1;
    check("abort1 busy after reset", {31'b0, busy3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_ack("abort1 no ack", 6);
    run_txn(rd20, "abort1 readback");

    // Reset on the very edge that would enter ACK
    @(negedge clk);
    wren = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; bmask = 4'b1111;
    @(posedge clk); #1;
    @(negedge clk);
    wren = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort2 ack at reset edge", {31'b0, ack3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_ack("abort2 no ack", 6);
    run_txn(rd20, "abort2 readback");

    // Held read: ACK spacing for each latency
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rden = 1'b1; addr = 32'h10;
    lat[0] = 1; lat[1] = 3; lat[2] = 15;
    for (int k = 0; k < 3; k++) begin
      last[k] = 0;
      cnt[k]  = 0;
    end
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      a[0] = ack1; a[1] = ack3; a[2] = ack15;
      for (int k = 0; k < 3; k++) begin
        if (a[k] === 1'b1) begin
          if (cnt[k] == 0) check($sformatf("L%0d first ack", lat[k]), c, lat[k]);
          else check($sformatf("L%0d ack spacing", lat[k]), c - last[k], lat[k] + 2);
          last[k] = c;
          cnt[k]++;
        end
      end
    end
    rden = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("L%0d ack count", lat[k]), cnt[k], (70 - lat[k]) / (lat[k] + 2) + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
